// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-Stream beat type, routing-header TID, arbiter states and wrap helper.
// Used by both the router input side and the output-side packet arbiter.
package axis_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int DEST_WIDTH = 4;
    localparam int USER_WIDTH = 4;
    localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = ID_WIDTH'(1);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] TDATA;
        logic [ID_WIDTH-1:0]   TID;
        logic [DEST_WIDTH-1:0] TDEST;
        logic [USER_WIDTH-1:0] TUSER;
        logic                  TLAST;
    } axis_data_t;
    // GAP is the single dead cycle after a multi-beat packet before re-arbitration.
    typedef enum logic [1:0] {IDLE, LOCKED, GAP} arb_state_t;
    function automatic int wrap_inc(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin priority scan starting at i_ptr.
// Ports: i_req request vector, i_ptr highest-priority index,
//        o_winner first requester at or after i_ptr (mod N), o_any any request present.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_winner,
    output logic         o_any
);
    logic [2*N-1:0] w_rot;
    logic [W:0]     w_off;
    logic [W:0]     w_sum;
    // Rotating a doubled vector puts req[ptr] at bit 0, so the lowest set bit is the winner offset.
    always_comb begin
        w_rot = {i_req, i_req} >> i_ptr;
        w_off = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (W+1)'(k);
                o_any = 1'b1;
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        o_winner = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : W'(w_sum);
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-granular round-robin merge of IN_NUMBER AXI-Stream channels.
// Ports: clk/rst (async active-high); in/in_valid/in_ready per-channel inputs;
//        out/out_valid/out_ready registered merged output; current_grant granted index;
//        locked packet in flight; orphan_err sticky non-header beat seen while idle.
module axis_packet_arbiter
    import axis_pkg::*;
#(
    parameter int IN_NUMBER       = 5,
    parameter int IN_NUMBER_WIDTH = $clog2(IN_NUMBER)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  axis_data_t                 in [IN_NUMBER],
    input  logic                       in_valid [IN_NUMBER],
    output logic                       in_ready [IN_NUMBER],
    output axis_data_t                 out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IN_NUMBER_WIDTH-1:0] current_grant,
    output logic                       locked,
    output logic                       orphan_err
);
    arb_state_t                 r_state;
    arb_state_t                 w_next_state;
    logic [IN_NUMBER_WIDTH-1:0] r_rr_ptr;
    logic [IN_NUMBER_WIDTH-1:0] r_grant;
    axis_data_t                 r_out;
    logic                       r_out_valid;
    logic                       r_orphan;
    logic [IN_NUMBER-1:0]       w_valid;
    logic [IN_NUMBER-1:0]       w_hdr;
    logic [IN_NUMBER-1:0]       w_sel_mask;
    logic [IN_NUMBER_WIDTH-1:0] w_winner;
    logic [IN_NUMBER_WIDTH-1:0] w_sel;
    logic                       w_any;
    logic                       w_accept;
    logic                       w_sel_req;
    logic                       w_fire;
    logic                       w_orphan;
    axis_data_t                 w_beat;

    always_comb begin
        w_valid = '0;
        w_hdr   = '0;
        for (int i = 0; i < IN_NUMBER; i++) begin
            w_valid[i] = in_valid[i];
            w_hdr[i]   = in_valid[i] && (in[i].TID == ROUTING_HEADER);
        end
    end

    rr_arbiter #(.N(IN_NUMBER), .W(IN_NUMBER_WIDTH)) u_rr (
        .i_req    (w_hdr),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Only one channel is ever offered ready: the scan winner while idle, the grant while locked.
    always_comb begin
        w_accept   = !r_out_valid || out_ready;
        w_sel      = (r_state == LOCKED) ? r_grant : w_winner;
        w_sel_req  = (r_state == LOCKED) || (r_state == IDLE && w_any);
        w_beat     = '0;
        w_sel_mask = '0;
        for (int i = 0; i < IN_NUMBER; i++) begin
            w_sel_mask[i] = (IN_NUMBER_WIDTH'(i) == w_sel);
            if (w_sel_mask[i]) w_beat = in[i];
            in_ready[i] = !rst && w_sel_req && w_accept && w_sel_mask[i];
        end
        w_fire   = w_sel_req && w_accept && |(w_valid & w_sel_mask);
        w_orphan = (r_state == IDLE) && |(w_valid & ~w_hdr);
        w_next_state = (r_state == GAP) ? IDLE
                     : !w_fire ? r_state
                     : (r_state == IDLE) ? (w_beat.TLAST ? IDLE : LOCKED)
                     : (w_beat.TLAST ? GAP : LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_orphan    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= w_fire || (r_out_valid && !out_ready);
            r_orphan    <= r_orphan || w_orphan;
            if (w_fire) begin
                r_grant <= w_sel;
                r_out   <= w_beat;
            end
            if (w_fire && w_beat.TLAST) r_rr_ptr <= IN_NUMBER_WIDTH'(wrap_inc(int'(w_sel), IN_NUMBER));
        end
    end

    assign out           = r_out;
    assign out_valid     = r_out_valid;
    assign current_grant = r_grant;
    assign locked        = (r_state == LOCKED);
    assign orphan_err    = r_orphan;
endmodule
